// File: rtl/rv32i_types_pkg.sv
// Scalar types shared with the integer pipeline: element width and register offset.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types_pkg;

   // Element width of a vector memory op.
   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2
   } sew_t;

   // Element offset within a destination vector register.
   typedef logic [3:0] offset_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// Vector load/store unit types: FSM state encoding and the lane alignment rule.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package rv32v_types_pkg;
   import rv32i_types_pkg::*;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC0   = 2'd1,
      ACC1   = 2'd2,
      FINISH = 2'd3
   } lsu_state_e;

   // A lane is misaligned when its address is not a multiple of the element size.
   function automatic logic addr_misaligned(input sew_t eew, input logic [1:0] a);
      case (eew)
         SEW8:    return 1'b0;
         SEW16:   return a[0];
         default: return |a;
      endcase
   endfunction

endpackage

// File: rtl/rv32v_mem_stage_if.sv
// Bundles for the vector memory stage: execute-side op, data bus, writeback.
// Latency: n/a (wires only).
// Backpressure: execute side is held by stall; data bus is held by dbus_busy.

// Execute -> memory stage op bundle, stall flows back.
interface rv32v_ex_if;
   logic                     ex_valid;
   logic                     load_ena;
   logic                     store_ena;
   logic [1:0]               wen;
   logic [31:0]              aluresult0;
   logic [31:0]              aluresult1;
   logic [31:0]              storedata0;
   logic [31:0]              storedata1;
   rv32i_types_pkg::sew_t    eew;
   logic [4:0]               vd;
   rv32i_types_pkg::offset_t woffset0;
   rv32i_types_pkg::offset_t woffset1;
   logic                     stall;

   modport master (output ex_valid, load_ena, store_ena, wen, aluresult0, aluresult1,
                          storedata0, storedata1, eew, vd, woffset0, woffset1,
                   input  stall);
   modport slave  (input  ex_valid, load_ena, store_ena, wen, aluresult0, aluresult1,
                          storedata0, storedata1, eew, vd, woffset0, woffset1,
                   output stall);
endinterface

// Memory stage -> data bus request, response flows back.
interface rv32v_dbus_if;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_byte_en;
   logic        dbus_ren;
   logic        dbus_wen;
   logic [31:0] dbus_rdata;
   logic        dbus_busy;

   modport master (output dbus_addr, dbus_wdata, dbus_byte_en, dbus_ren, dbus_wen,
                   input  dbus_rdata, dbus_busy);
   modport slave  (input  dbus_addr, dbus_wdata, dbus_byte_en, dbus_ren, dbus_wen,
                   output dbus_rdata, dbus_busy);
endinterface

// Memory stage -> writeback bundle.
interface rv32v_wb_if;
   logic                     wb_valid;
   logic [1:0]               wb_wen;
   logic [31:0]              wb_wdat0;
   logic [31:0]              wb_wdat1;
   rv32i_types_pkg::offset_t wb_woffset0;
   rv32i_types_pkg::offset_t wb_woffset1;
   logic [4:0]               wb_vd;
   logic                     misaligned;

   modport master (output wb_valid, wb_wen, wb_wdat0, wb_wdat1, wb_woffset0, wb_woffset1,
                          wb_vd, misaligned);
   modport slave  (input  wb_valid, wb_wen, wb_wdat0, wb_wdat1, wb_woffset0, wb_woffset1,
                          wb_vd, misaligned);
endinterface

// File: rtl/rv32v_mem_stage_lane_align.sv
// Per-lane byte steering: byte enables, store data shift, load extract + zero-extend.
// Latency: combinational.
// Backpressure: none.
// Ports: eew_i/addr_lo_i select width and byte offset; sdat_i/rdata_i raw data;
//        byte_en_o/wdata_o feed the bus, rdat_o is the lane load result.
module rv32v_lane_align
   import rv32i_types_pkg::*;
(
   input  sew_t        eew_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] sdat_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdat_o
);

   logic [4:0]  shamt;
   logic [31:0] rdata_sh;

   assign shamt    = {addr_lo_i, 3'b000};
   assign wdata_o  = sdat_i << shamt;
   assign rdata_sh = rdata_i >> shamt;

   // Only aligned lanes reach the bus, so the shifted enables never overflow.
   always_comb begin
      byte_en_o = 4'b1111;
      rdat_o    = rdata_sh;
      case (eew_i)
         SEW8: begin
            byte_en_o = 4'b0001 << addr_lo_i;
            rdat_o    = {24'h0, rdata_sh[7:0]};
         end
         SEW16: begin
            byte_en_o = 4'b0011 << addr_lo_i;
            rdat_o    = {16'h0, rdata_sh[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32v_mem_stage.sv
// Two-lane vector memory stage: serialises lane loads/stores onto one data bus.
// Latency: 1 cycle for non-mem ops; 2 + accessed lanes + busy cycles for mem ops.
// Backpressure: stall holds execute during a mem op; bus request held while dbus_busy.
// Ports: clk_i/rst_i (sync active-high); ex = execute op in, dbus = data bus master,
//        wb = registered writeback bundle with misaligned flag.
module rv32v_mem_stage
   import rv32i_types_pkg::*;
   import rv32v_types_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   rv32v_ex_if.slave    ex,
   rv32v_dbus_if.master dbus,
   rv32v_wb_if.master   wb
);

   lsu_state_e  state_q, state_d;

   // Captured op
   logic        is_ld_q, is_st_q;
   logic [1:0]  acc_q;            // lanes that go to the bus
   logic [1:0]  mis_q;            // enabled lanes dropped for misalignment
   logic [31:0] addr0_q, addr1_q, sdat0_q, sdat1_q;
   logic [31:0] rdat0_q, rdat1_q;
   sew_t        eew_q;
   logic [4:0]  vd_q;
   offset_t     woff0_q, woff1_q;

   // Writeback registers
   logic        wb_valid_q;
   logic [1:0]  wb_wen_q;
   logic [31:0] wb_wdat0_q, wb_wdat1_q;
   offset_t     wb_woff0_q, wb_woff1_q;
   logic [4:0]  wb_vd_q;
   logic        wb_mis_q;

   logic        mem_op;
   logic [1:0]  mis_in, acc_in;
   logic        lane_sel;
   logic [31:0] lane_addr, lane_sdat, lane_wdata, lane_rdat;
   logic [3:0]  lane_be;

   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ren, bus_wen;

   assign mem_op    = ex.ex_valid & (ex.load_ena | ex.store_ena);
   assign mis_in[0] = ex.wen[0] & addr_misaligned(ex.eew, ex.aluresult0[1:0]);
   assign mis_in[1] = ex.wen[1] & addr_misaligned(ex.eew, ex.aluresult1[1:0]);
   assign acc_in    = ex.wen & ~mis_in;

   // Execute may advance in FINISH: the op is consumed at that edge.
   assign ex.stall  = mem_op & (state_q != FINISH);

   assign lane_sel  = (state_q == ACC1);
   assign lane_addr = lane_sel ? addr1_q : addr0_q;
   assign lane_sdat = lane_sel ? sdat1_q : sdat0_q;

   rv32v_lane_align u_align (
      .eew_i     (eew_q),
      .addr_lo_i (lane_addr[1:0]),
      .sdat_i    (lane_sdat),
      .rdata_i   (dbus.dbus_rdata),
      .byte_en_o (lane_be),
      .wdata_o   (lane_wdata),
      .rdat_o    (lane_rdat)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (acc_in[0])      state_d = ACC0;
               else if (acc_in[1]) state_d = ACC1;
               else                state_d = FINISH;
            end
         end
         ACC0:    if (!dbus.dbus_busy) state_d = acc_q[1] ? ACC1 : FINISH;
         ACC1:    if (!dbus.dbus_busy) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus request outputs; quiet outside the access states
   always_comb begin
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      bus_be    = 4'h0;
      bus_ren   = 1'b0;
      bus_wen   = 1'b0;
      if ((state_q == ACC0) || (state_q == ACC1)) begin
         bus_addr  = {lane_addr[31:2], 2'b00};
         bus_wdata = lane_wdata;
         bus_be    = lane_be;
         bus_ren   = is_ld_q;
         bus_wen   = is_st_q;
      end
   end

   assign dbus.dbus_addr    = bus_addr;
   assign dbus.dbus_wdata   = bus_wdata;
   assign dbus.dbus_byte_en = bus_be;
   assign dbus.dbus_ren     = bus_ren;
   assign dbus.dbus_wen     = bus_wen;

   // Capture, load result sampling and writeback
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         is_ld_q    <= 1'b0;
         is_st_q    <= 1'b0;
         acc_q      <= 2'b00;
         mis_q      <= 2'b00;
         addr0_q    <= 32'h0;
         addr1_q    <= 32'h0;
         sdat0_q    <= 32'h0;
         sdat1_q    <= 32'h0;
         rdat0_q    <= 32'h0;
         rdat1_q    <= 32'h0;
         eew_q      <= SEW8;
         vd_q       <= 5'h0;
         woff0_q    <= '0;
         woff1_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_wen_q   <= 2'b00;
         wb_wdat0_q <= 32'h0;
         wb_wdat1_q <= 32'h0;
         wb_woff0_q <= '0;
         wb_woff1_q <= '0;
         wb_vd_q    <= 5'h0;
         wb_mis_q   <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_op) begin
                  is_ld_q <= ex.load_ena;
                  is_st_q <= ex.store_ena;
                  acc_q   <= acc_in;
                  mis_q   <= mis_in;
                  addr0_q <= ex.aluresult0;
                  addr1_q <= ex.aluresult1;
                  sdat0_q <= ex.storedata0;
                  sdat1_q <= ex.storedata1;
                  rdat0_q <= 32'h0;
                  rdat1_q <= 32'h0;
                  eew_q   <= ex.eew;
                  vd_q    <= ex.vd;
                  woff0_q <= ex.woffset0;
                  woff1_q <= ex.woffset1;
               end else if (ex.ex_valid) begin
                  wb_valid_q <= 1'b1;
                  wb_wen_q   <= ex.wen;
                  wb_wdat0_q <= ex.aluresult0;
                  wb_wdat1_q <= ex.aluresult1;
                  wb_woff0_q <= ex.woffset0;
                  wb_woff1_q <= ex.woffset1;
                  wb_vd_q    <= ex.vd;
                  wb_mis_q   <= 1'b0;
               end
            end
            ACC0: if (!dbus.dbus_busy && is_ld_q) rdat0_q <= lane_rdat;
            ACC1: if (!dbus.dbus_busy && is_ld_q) rdat1_q <= lane_rdat;
            FINISH: begin
               wb_valid_q <= 1'b1;
               wb_wen_q   <= is_ld_q ? acc_q : 2'b00;
               wb_wdat0_q <= rdat0_q;
               wb_wdat1_q <= rdat1_q;
               wb_woff0_q <= woff0_q;
               wb_woff1_q <= woff1_q;
               wb_vd_q    <= vd_q;
               wb_mis_q   <= |mis_q;
            end
            default: ;
         endcase
      end
   end

   assign wb.wb_valid    = wb_valid_q;
   assign wb.wb_wen      = wb_wen_q;
   assign wb.wb_wdat0    = wb_wdat0_q;
   assign wb.wb_wdat1    = wb_wdat1_q;
   assign wb.wb_woffset0 = wb_woff0_q;
   assign wb.wb_woffset1 = wb_woff1_q;
   assign wb.wb_vd       = wb_vd_q;
   assign wb.misaligned  = wb_mis_q;

endmodule

// File: tb/tb_rv32v_mem_stage.sv
// Self-checking bench for rv32v_mem_stage: directed ops, reset abort, randomized ops.
// Latency: n/a.
// Backpressure: bench plays the data bus and inserts busy cycles.
module tb_rv32v_mem_stage;
   import rv32i_types_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   rv32v_ex_if   ex_b ();
   rv32v_dbus_if db_b ();
   rv32v_wb_if   wb_b ();

   rv32v_mem_stage dut (
      .clk_i (clk),
      .rst_i (rst),
      .ex    (ex_b),
      .dbus  (db_b),
      .wb    (wb_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ex_idle();
      ex_b.ex_valid   = 1'b0;
      ex_b.load_ena   = 1'b0;
      ex_b.store_ena  = 1'b0;
      ex_b.wen        = 2'b00;
      ex_b.aluresult0 = 32'h0;
      ex_b.aluresult1 = 32'h0;
      ex_b.storedata0 = 32'h0;
      ex_b.storedata1 = 32'h0;
      ex_b.eew        = SEW8;
      ex_b.vd         = 5'h0;
      ex_b.woffset0   = '0;
      ex_b.woffset1   = '0;
   endtask

   // Presents one op, acts as the bus slave and checks every request and the writeback
   // against a per-lane arithmetic model of the op.
   task automatic run_op(input logic ld, input logic st, input logic [1:0] wen,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] sd0, input logic [31:0] sd1,
                         input sew_t eew, input logic [4:0] vd,
                         input offset_t o0, input offset_t o1,
                         input int bz0, input int bz1,
                         input bit use_fixed, input logic [31:0] fixed_rd);
      logic [31:0] addr [2];
      logic [31:0] sdat [2];
      logic [31:0] res  [2];
      int          bz   [2];
      logic [31:0] q_addr [$];
      logic [3:0]  q_be   [$];
      logic [31:0] q_wd   [$];
      int          q_lane [$];
      int          q_bz   [$];
      logic [1:0]  exp_wen;
      logic        exp_mis;
      bit          mem, consumed, done;
      int          nb, off, lat_exp, cyc, bei;
      logic [63:0] w;
      logic [31:0] rd;

      addr[0] = a0;  addr[1] = a1;
      sdat[0] = sd0; sdat[1] = sd1;
      bz[0]   = bz0; bz[1]   = bz1;
      res[0]  = a0;  res[1]  = a1;
      mem     = ld | st;
      nb      = (eew == SEW8) ? 1 : (eew == SEW16) ? 2 : 4;
      exp_mis = 1'b0;
      exp_wen = mem ? 2'b00 : wen;
      lat_exp = mem ? 2 : 1;

      if (mem) begin
         for (int i = 0; i < 2; i++) begin
            if (wen[i]) begin
               if ((addr[i] % nb) != 0) begin
                  exp_mis = 1'b1;
               end else begin
                  off = int'(addr[i] % 32'd4);
                  bei = ((1 << nb) - 1) << off;
                  w   = {32'h0, sdat[i]} << (8 * off);
                  q_addr.push_back(addr[i] - (addr[i] % 32'd4));
                  q_be.push_back(bei[3:0]);
                  q_wd.push_back(w[31:0]);
                  q_lane.push_back(i);
                  q_bz.push_back(bz[i]);
                  lat_exp += 1 + bz[i];
                  if (ld) exp_wen[i] = 1'b1;
               end
            end
         end
      end

      ex_b.ex_valid   = 1'b1;
      ex_b.load_ena   = ld;
      ex_b.store_ena  = st;
      ex_b.wen        = wen;
      ex_b.aluresult0 = a0;
      ex_b.aluresult1 = a1;
      ex_b.storedata0 = sd0;
      ex_b.storedata1 = sd1;
      ex_b.eew        = eew;
      ex_b.vd         = vd;
      ex_b.woffset0   = o0;
      ex_b.woffset1   = o1;
      db_b.dbus_busy  = 1'b0;
      #1;
      chk("stall_c0", ex_b.stall, mem);
      consumed = !ex_b.stall;

      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (consumed) ex_idle();
         #1;
         if (wb_b.wb_valid) begin
            done = 1'b1;
         end else begin
            if (!consumed) begin
               chk("stall_hold", ex_b.stall, (cyc != lat_exp - 1));
               consumed = !ex_b.stall;
            end
            db_b.dbus_busy  = 1'b0;
            db_b.dbus_rdata = $urandom;
            if (db_b.dbus_ren | db_b.dbus_wen) begin
               if (q_addr.size() == 0) begin
                  chk("extra_req", {db_b.dbus_ren, db_b.dbus_wen}, 32'h0);
               end else begin
                  chk("req_addr", db_b.dbus_addr, q_addr[0]);
                  chk("req_be", db_b.dbus_byte_en, q_be[0]);
                  chk("req_ren", db_b.dbus_ren, ld);
                  chk("req_wen", db_b.dbus_wen, st);
                  if (st) chk("req_wdata", db_b.dbus_wdata, q_wd[0]);
                  if (q_bz[0] > 0) begin
                     q_bz[0] = q_bz[0] - 1;
                     db_b.dbus_busy = 1'b1;
                  end else begin
                     rd  = use_fixed ? fixed_rd : $urandom;
                     db_b.dbus_rdata = rd;
                     off = int'(addr[q_lane[0]] % 32'd4);
                     w   = {32'h0, rd} >> (8 * off);
                     res[q_lane[0]] = (nb == 4) ? w[31:0] : (w[31:0] & ((32'h1 << (8 * nb)) - 1));
                     void'(q_addr.pop_front());
                     void'(q_be.pop_front());
                     void'(q_wd.pop_front());
                     void'(q_lane.pop_front());
                     void'(q_bz.pop_front());
                  end
               end
            end
         end
      end

      chk("wb_latency", cyc, lat_exp);
      if (done) begin
         chk("wb_wen", wb_b.wb_wen, exp_wen);
         chk("wb_misaligned", wb_b.misaligned, exp_mis);
         chk("wb_vd", wb_b.wb_vd, vd);
         chk("wb_woffset0", wb_b.wb_woffset0, o0);
         chk("wb_woffset1", wb_b.wb_woffset1, o1);
         if (exp_wen[0]) chk("wb_wdat0", wb_b.wb_wdat0, res[0]);
         if (exp_wen[1]) chk("wb_wdat1", wb_b.wb_wdat1, res[1]);
         chk("req_missing", q_addr.size(), 0);
      end
      ex_idle();
      db_b.dbus_busy = 1'b0;
      @(posedge clk);
      #2;
      chk("wb_pulse", wb_b.wb_valid, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      ex_idle();
      db_b.dbus_busy  = 1'b0;
      db_b.dbus_rdata = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ren", db_b.dbus_ren, 0);
      chk("rst_wen", db_b.dbus_wen, 0);
      chk("rst_addr", db_b.dbus_addr, 0);
      chk("rst_be", db_b.dbus_byte_en, 0);
      chk("rst_stall", ex_b.stall, 0);
      chk("rst_wb_valid", wb_b.wb_valid, 0);
      chk("rst_wb_wen", wb_b.wb_wen, 0);
      chk("rst_wb_wdat0", wb_b.wb_wdat0, 0);
      chk("rst_misaligned", wb_b.misaligned, 0);
      rst = 1'b0;

      // Non-mem op: one-cycle pass-through
      run_op(1'b0, 1'b0, 2'b11, 32'h11, 32'h22, 32'h0, 32'h0, SEW32, 5'd3, 4'd1, 4'd2,
             0, 0, 1'b0, 32'h0);
      // SEW8 load, both lanes, no wait
      run_op(1'b1, 1'b0, 2'b11, 32'h1003, 32'h2001, 32'h0, 32'h0, SEW8, 5'd7, 4'd0, 4'd1,
             0, 0, 1'b1, 32'hAABBCCDD);
      // SEW16 store lane 0 at byte 2 with 3 busy cycles
      run_op(1'b0, 1'b1, 2'b01, 32'h102, 32'h0, 32'h1234, 32'h0, SEW16, 5'd9, 4'd2, 4'd3,
             3, 0, 1'b0, 32'h0);
      // SEW32 load with lane 0 misaligned
      run_op(1'b1, 1'b0, 2'b11, 32'h101, 32'h204, 32'h0, 32'h0, SEW32, 5'd12, 4'd4, 4'd5,
             0, 1, 1'b0, 32'h0);
      // Mem op with no enabled lanes
      run_op(1'b1, 1'b0, 2'b00, 32'h300, 32'h304, 32'h0, 32'h0, SEW32, 5'd1, 4'd0, 4'd0,
             0, 0, 1'b0, 32'h0);
      // SEW16 store on lane 1 only, byte 0 and misaligned odd lane 0 disabled
      run_op(1'b0, 1'b1, 2'b10, 32'h3, 32'h4444, 32'h0, 32'hBEEF, SEW16, 5'd2, 4'd6, 4'd7,
             0, 2, 1'b0, 32'h0);

      // Reset during ACC1 with the bus busy abandons the op
      ex_b.ex_valid   = 1'b1;
      ex_b.load_ena   = 1'b1;
      ex_b.wen        = 2'b11;
      ex_b.aluresult0 = 32'h100;
      ex_b.aluresult1 = 32'h204;
      ex_b.eew        = SEW32;
      db_b.dbus_busy  = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_acc0_ren", db_b.dbus_ren, 1);
      @(posedge clk);
      #2;
      chk("abort_acc1_ren", db_b.dbus_ren, 1);
      chk("abort_acc1_addr", db_b.dbus_addr, 32'h204);
      db_b.dbus_busy = 1'b1;
      rst = 1'b1;
      ex_idle();
      @(posedge clk);
      #2;
      chk("abort_ren", db_b.dbus_ren, 0);
      chk("abort_addr", db_b.dbus_addr, 0);
      chk("abort_stall", ex_b.stall, 0);
      chk("abort_wb_valid", wb_b.wb_valid, 0);
      rst = 1'b0;
      db_b.dbus_busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2;
         chk("abort_no_wb", wb_b.wb_valid, 0);
         chk("abort_no_req", {db_b.dbus_ren, db_b.dbus_wen}, 0);
      end

      // Randomized ops
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 2);
         run_op(kind == 1, kind == 2, 2'($urandom_range(0, 3)),
                $urandom, $urandom, $urandom, $urandom,
                sew_t'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32v_mem_stage.md
RV32V_MEM_STAGE -- requirements
Module: rv32v_mem_stage

Interface
- REQ-001 Parameters: none; all widths fixed (32-bit data/address, 2 lanes).
- REQ-002 CLK  in  1  single clock; all state changes on rising edge.
- REQ-003 RST  in  1  reset; synchronous, active-high.
- REQ-004 ex_valid  in  1  execute-side op present.
- REQ-005 load_ena / store_ena  in  1 each  op is vector load / vector store; never both high.
- REQ-006 wen  in  2  per-lane element enable (bit0 = lane 0, bit1 = lane 1).
- REQ-007 aluresult0 / aluresult1  in  32 each  lane address for mem ops, lane result otherwise.
- REQ-008 storedata0 / storedata1  in  32 each  lane store data, right-aligned.
- REQ-009 eew  in  sew_t  element width SEW8/SEW16/SEW32.
- REQ-010 vd  in  5; woffset0 / woffset1  in  offset_t  destination register and element offsets.
- REQ-011 stall  out  1  hold request to execute stage.
- REQ-012 dbus_addr  out  32; dbus_wdata  out  32; dbus_byte_en  out  4; dbus_ren / dbus_wen  out  1 each  data bus request.
- REQ-013 dbus_rdata  in  32; dbus_busy  in  1  bus response; access completes in the cycle dbus_busy is low.
- REQ-014 wb_valid  out  1; wb_wen  out  2; wb_wdat0 / wb_wdat1  out  32; wb_woffset0 / wb_woffset1  out  offset_t; wb_vd  out  5  writeback bundle.
- REQ-015 misaligned  out  1  qualifies wb_valid: at least one lane address was misaligned.

Function
- REQ-016 FSM states: IDLE, ACC0, ACC1, FINISH.
- REQ-017 IDLE, ex_valid, no mem op: wb bundle loaded from inputs; wb_valid high the next cycle for one cycle; stall low; latency 1.
- REQ-018 IDLE, ex_valid with load_ena or store_ena: capture all inputs; go to ACC0 if wen[0], else ACC1 if wen[1], else FINISH.
- REQ-019 stall = ex_valid & (load_ena | store_ena) & (state != FINISH).
- REQ-020 ACCn: drive the bus request from lane n captured data and hold it stable while dbus_busy is high; on dbus_busy low, sample dbus_rdata and advance.
- REQ-021 Advance from ACC0: to ACC1 if wen[1], else FINISH. Advance from ACC1: to FINISH.
- REQ-022 FINISH lasts exactly one cycle and then returns to IDLE; wb bundle loads at the FINISH edge; no new capture occurs in FINISH.
- REQ-023 Alignment rule: SEW16 requires addr[0]=0; SEW32 requires addr[1:0]=0.
- REQ-024 A misaligned lane issues no bus request, consumes zero ACC cycles, clears its wb_wen bit, and sets misaligned.
- REQ-025 dbus_byte_en: SEW8 = 4'b0001<<a; SEW16 = 4'b0011<<a; SEW32 = 4'b1111; a = addr[1:0].
- REQ-026 dbus_wdata = storedata << (8*a).
- REQ-027 Load lane result = (rdata >> 8*a) masked to eew, then zero-extended to 32.
- REQ-028 Stores produce wb_wen = 2'b00; loads produce wb_wen = captured wen minus misaligned lanes.
- REQ-029 dbus_addr = {addr[31:2], 2'b00}.
- REQ-030 dbus_ren and dbus_wen are low in IDLE and FINISH.
- REQ-031 Mem-op latency: wb_valid appears 2 + (number of accessed lanes) + (total busy cycles) cycles after capture.

Reset
- REQ-032 RST high at any edge, including mid-access: state = IDLE and all outputs = 0 from the next cycle.
- REQ-033 An in-flight request is abandoned on reset: no writeback and no retry.

Structure
- REQ-034 The lsu state enum belongs in rv32v_types_pkg; sew_t and offset_t come from rv32i_types_pkg.
- REQ-035 One combinational sub-module, rv32v_lane_align, implements byte-enable generation, store shifting and load extraction/extension; it is instantiated once and muxed by the active lane.

Verification
- REQ-036 Non-mem op: wen=11, aluresult0=0x11, aluresult1=0x22 -> next cycle wb_valid=1, wb_wdat0=0x11, wb_wdat1=0x22, stall never high.
- REQ-037 Load SEW8, wen=11, addr0=0x1003, addr1=0x2001, rdata 0xAABBCCDD both, zero wait -> wb_wdat0=0xAA, wb_wdat1=0xCC, wb_valid 4 cycles after capture.
- REQ-038 Store SEW16, wen=01, addr0=0x102, storedata0=0x1234, dbus_busy high for 3 cycles -> addr=0x100, byte_en=1100, wdata=0x12340000, held 4 cycles; wb_wen=00.
- REQ-039 Load SEW32, wen=11, addr0=0x101 -> lane0 gets no request, misaligned=1, wb_wen=10.
- REQ-040 Mem op with wen=00 -> no bus activity, wb_valid exactly 2 cycles after capture.
- REQ-041 RST asserted during ACC1 with busy high -> next cycle dbus_ren=0, state IDLE, no wb_valid.
